// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty thresholds, sticky overflow/underflow flags and a
//   selectable read mode: registered (FWFT=0) or first-word-fall-through
//   (FWFT=1).
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   wdata        in   write data
//   wr_en        in   push request
//   rd_en        in   pop request (acknowledge of the head word in FWFT mode)
//   clr_err      in   synchronous clear of overflow/underflow
//   rdata        out  read data
//   rd_valid     out  rdata holds a valid popped (FWFT=0) or head (FWFT=1) word
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  occupancy 0..DEPTH
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
//
// Handshake: a push is taken on any rising edge where wr_en=1 and the FIFO
// is not full, or is full but a pop is taken in the same cycle. A pop is
// taken on any rising edge where rd_en=1 and the FIFO is not empty. A
// request that is not taken is dropped (not held) and sets the matching
// sticky error flag. There is no write-through from an empty FIFO.

module sync_fifo_flags #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Elaboration-time parameter checks
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc, wr_acc;

  // Status flags are pure decodes of the registered count, so they move in
  // the same cycle as count and clear immediately on asynchronous reset.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A pop at full frees a slot, so the push in the same cycle is taken.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky errors: a new rejection in the same cycle as clr_err wins.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && !wr_acc) ovf_d = 1'b1;
    if (rd_en && !rd_acc) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible whenever the FIFO holds data; rd_en acknowledges it.
    assign rdata    = mem_q[rptr_q];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    logic             rd_valid_q;

    // rdata holds the last popped word; rd_valid pulses for one cycle per pop.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q    <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_q[rptr_q];
      end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags: a registered-read instance and an FWFT
// instance driven by the same stimulus and checked against a queue model.

module tb_sync_fifo_flags;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  localparam int CW = $clog2(D) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] wdata   = '0;
  logic         wr_en   = 1'b0;
  logic         rd_en   = 1'b0;
  logic         clr_err = 1'b0;

  logic [W-1:0]  d0_rdata, d1_rdata;
  logic          d0_rv, d1_rv;
  logic          d0_full, d1_full, d0_empty, d1_empty;
  logic          d0_af, d1_af, d0_ae, d1_ae;
  logic [CW-1:0] d0_count, d1_count;
  logic          d0_ovf, d1_ovf, d0_unf, d1_unf;

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .rdata(d0_rdata), .rd_valid(d0_rv), .full(d0_full), .empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_unf)
  );

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .rdata(d1_rdata), .rd_valid(d1_rv), .full(d1_full), .empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_unf)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd0;
  logic         exp_rv0;
  logic         exp_ovf;
  logic         exp_unf;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rd0 = '0;
    exp_rv0 = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count_reg",  32'(d0_count), 32'(n));
    chk("count_fwft", 32'(d1_count), 32'(n));
    chk("empty_reg",  32'(d0_empty), 32'(n == 0));
    chk("empty_fwft", 32'(d1_empty), 32'(n == 0));
    chk("full_reg",   32'(d0_full),  32'(n == D));
    chk("full_fwft",  32'(d1_full),  32'(n == D));
    chk("afull_reg",  32'(d0_af),    32'(n >= AF));
    chk("afull_fwft", 32'(d1_af),    32'(n >= AF));
    chk("aempty_reg", 32'(d0_ae),    32'(n <= AE));
    chk("aempty_fwft",32'(d1_ae),    32'(n <= AE));
    chk("ovf_reg",    32'(d0_ovf),   32'(exp_ovf));
    chk("ovf_fwft",   32'(d1_ovf),   32'(exp_ovf));
    chk("unf_reg",    32'(d0_unf),   32'(exp_unf));
    chk("unf_fwft",   32'(d1_unf),   32'(exp_unf));
    chk("rvalid_reg", 32'(d0_rv),    32'(exp_rv0));
    chk("rdata_reg",  d0_rdata,      exp_rd0);
    chk("rvalid_fwft",32'(d1_rv),    32'(n != 0));
    if (n != 0) chk("rdata_fwft", d1_rdata, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of requests, advance the model, then check after the edge.
  task automatic cycle(input logic wr, input logic rd, input logic [W-1:0] wd, input logic clr);
    logic rd_acc, wr_acc;
    wr_en   = wr;
    rd_en   = rd;
    wdata   = wd;
    clr_err = clr;
    rd_acc = rd && (exp_q.size() > 0);
    wr_acc = wr && ((exp_q.size() < D) || rd_acc);
    if (rd_acc) begin
      exp_rd0 = exp_q.pop_front();
      exp_rv0 = 1'b1;
    end else begin
      exp_rv0 = 1'b0;
    end
    if (wr_acc) exp_q.push_back(wd);
    if (clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
    if (wr && !wr_acc) exp_ovf = 1'b1;
    if (rd && !rd_acc) exp_unf = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p_wr, p_rd;
    model_reset();
    #2;
    check_all();            // reset state before any edge
    #10 rst = 1'b1;         // released between edges

    // fill / overflow / drain
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0);
    cycle(1'b1, 1'b0, 32'hDEAD, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // read/write-through at full
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'hC0 + 32'(i), 1'b0);
    cycle(1'b1, 1'b1, 32'hBEEF, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b0);

    // push + pop on empty: pop rejected, push taken
    cycle(1'b1, 1'b1, 32'h55, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // FWFT head visibility then acknowledge
    cycle(1'b1, 1'b0, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);

    // interleaved push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, $urandom, 1'b0);
      cycle(1'b0, 1'b1, '0, 1'b0);
    end

    // randomized phases biased toward filling, then draining
    for (int i = 0; i < 400; i++) begin
      p_wr = ((i / 50) % 2 == 0) ? 75 : 30;
      p_rd = ((i / 50) % 2 == 0) ? 30 : 75;
      cycle($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd,
            $urandom, $urandom_range(0, 15) == 0);
    end

    // asynchronous reset with five words stored
    while (exp_q.size() > 0) cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h70 + 32'(i), 1'b0);
    chk("count_before_rst", 32'(d0_count), 32'd5);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();            // cleared without any clock edge
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // traffic after reset
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
